shot_detector: RTL and testbench
================================

Name: shot_detector

Overview:
- Consumes the filtered flick-magnitude stream from the shot filter, one 16-bit unsigned value per sample strobe.
- Detects a single shot gesture: threshold crossing, peak tracking, then release.
- Emits a one-cycle shot event carrying peak, quantised power and duration.
- Lives in the 4 MHz accelerometer domain, between the shot filter and the game/physics logic and debug display.

Parameters:
- TRIG_THRESH, 16'd200: flick at or above this value starts a shot.
- RELEASE_THRESH, 16'd100: flick strictly below this value ends a shot. Must be ≤ TRIG_THRESH.
- MIN_SAMPLES, 3: shots shorter than this many samples are rejected as glitches.
- MAX_SAMPLES, 64: duration cap; a shot is forced to report at this count.
- COOLDOWN_CYCLES, 400000: clk cycles of lockout after a report (100 ms at 4 MHz).
- POWER_SHIFT, 8: right-shift applied to peak before quantisation.
- POWER_BITS, 4: width of shot_power.

Ports:
- clk in 1: system clock (4 MHz domain).
- rst in 1: synchronous, active-high reset.
- sample_valid in 1: one-cycle strobe marking a new flick sample.
- flick in 16: unsigned flick magnitude; sampled only when sample_valid=1.
- arm in 1: level; detection is enabled while high.
- shot_valid out 1: one-cycle pulse when a shot is reported.
- shot_peak out 16: maximum flick seen during the shot.
- shot_power out POWER_BITS: saturated, quantised peak.
- shot_dur out 7: number of samples in the shot (1..MAX_SAMPLES).
- busy out 1: high in TRACK, REPORT and COOLDOWN.
- state_dbg out 3: current state encoding, for LEDs and 7-seg.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs 0, peak/dur/cooldown counters cleared.
  - Reset mid-shot or mid-cooldown discards everything; no pulse is issued.
- IDLE (0): when arm=1, go to ARMED on the next clk.
- ARMED (1):
  - arm=0 → IDLE.
  - sample_valid=1 and flick≥TRIG_THRESH → TRACK, with peak=flick and dur=1.
  - A sample equal to TRIG_THRESH triggers.
- TRACK (2): each cycle with sample_valid=1:
  - If flick<RELEASE_THRESH:
    - dur≥MIN_SAMPLES → REPORT.
    - Otherwise → ARMED, shot dropped with no pulse.
  - Otherwise peak=max(peak, flick) and dur=dur+1.
  - If the incremented dur equals MAX_SAMPLES → REPORT. The cap sample is included in peak.
  - arm=0 → IDLE, abort, no pulse. arm is evaluated before any sample arriving in the same cycle.
- REPORT (3): lasts exactly one cycle.
  - shot_valid=1; shot_peak/shot_power/shot_dur driven from the tracked values.
  - Next state is COOLDOWN regardless of arm.
- COOLDOWN (4):
  - Counter runs from 0 to COOLDOWN_CYCLES-1; samples are ignored.
  - At terminal count: → ARMED if arm=1, else IDLE.
  - arm=0 does not shorten cooldown.
- Latency: shot_valid asserts one clk after the release (or cap) sample's strobe.
- Power rule:
  - p = peak >> POWER_SHIFT.
  - shot_power = (p > 2^POWER_BITS-1) ? all-ones : p[POWER_BITS-1:0].
  - Combinational from latched peak; no rounding.
- Width rule: dur saturates and never wraps, because MAX_SAMPLES ≤ 127 is enforced by elaboration-time check.
- Back-to-back sample_valid on consecutive cycles must be handled; there is no minimum sample spacing.
- sample_valid held high for multiple cycles counts as multiple samples.
- state_dbg encoding: IDLE=0, ARMED=1, TRACK=2, REPORT=3, COOLDOWN=4.

Optional Feature:
- Macro: SHOT_DETECTOR_HOLD_EN.
- Defined: shot_peak/shot_power/shot_dur are registered at REPORT and held until the next REPORT or rst. This supports the freeze-style 7-seg/LED display.
- Undefined: these outputs are non-zero only during the shot_valid cycle and read 0 otherwise.

Decomposition:
- Package shot_pkg:
  - State encoding constants (3-bit).
  - FLICK_W=16 and DUR_W=7.
  - Default threshold constants, shared with the shot filter and top level.
- One sub-module: shot_cooldown_timer.
  - Ports: clk, rst, start, done.
  - Parameter: CYCLES.
  - Loadable down-counter; done pulses one cycle at expiry.

Test Plan:
- arm=1; samples 50,250,400,300,80 → one shot_valid one clk after the 80 strobe; peak=400, power=1, dur=3. busy stays high for 1+400000 cycles, then state_dbg=1.
- arm=1; samples 250,260,40 (dur 2<MIN) → no shot_valid; state_dbg returns to 1; the next 300,300,300,10 is detected with dur=3.
- arm=1; 70 consecutive samples of 5000 → shot_valid after sample 64; dur=64, peak=5000, power=15 (5000>>8=19, saturated).
- Shot in progress at dur=2; arm→0 → state_dbg=0 next clk, no pulse. Separately, rst=1 during COOLDOWN → all outputs 0, IDLE.
- During COOLDOWN, feed 1000,1000,1000,0 → no trigger; a shot started after cooldown expiry is reported normally.
- With SHOT_DETECTOR_HOLD_EN: shot_peak holds 400 for 1000 cycles after the pulse. Without the macro: shot_peak=0 in the cycle after the pulse.

Source files
------------

// File: rtl/shot_pkg.sv
// shot_pkg: state encoding, datapath widths and default thresholds shared by the shot path
package shot_pkg;
  localparam int FLICK_W = 16;
  localparam int DUR_W = 7;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_TRACK    = 3'd2,
    S_REPORT   = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;
  localparam logic [FLICK_W-1:0] TRIG_THRESH_DEF = 16'd200;
  localparam logic [FLICK_W-1:0] RELEASE_THRESH_DEF = 16'd100;
endpackage

// File: rtl/shot_cooldown_timer.sv
// shot_cooldown_timer: loadable down-counter, done is high during the last of CYCLES counted cycles
module shot_cooldown_timer #(
  parameter int CYCLES = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  logic run;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= W'(CYCLES - 1);
      run <= 1'b1;
    end else if (run) begin
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
    end
  end
  assign done = run && cnt == '0;
endmodule

// File: rtl/shot_detector.sv
// shot_detector: threshold/peak/release shot gesture detector with cooldown lockout.
// Define SHOT_DETECTOR_HOLD_EN to hold the last report on shot_peak/shot_power/shot_dur.
module shot_detector import shot_pkg::*; #(
  parameter logic [FLICK_W-1:0] TRIG_THRESH = TRIG_THRESH_DEF,
  parameter logic [FLICK_W-1:0] RELEASE_THRESH = RELEASE_THRESH_DEF,
  parameter int MIN_SAMPLES = 3,
  parameter int MAX_SAMPLES = 64,
  parameter int COOLDOWN_CYCLES = 400000,
  parameter int POWER_SHIFT = 8,
  parameter int POWER_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [FLICK_W-1:0]    flick,
  input  logic                  arm,
  output logic                  shot_valid,
  output logic [FLICK_W-1:0]    shot_peak,
  output logic [POWER_BITS-1:0] shot_power,
  output logic [DUR_W-1:0]      shot_dur,
  output logic                  busy,
  output logic [2:0]            state_dbg
);
  if (MAX_SAMPLES > 127 || MAX_SAMPLES < 2) begin : g_bad_max
    $error("shot_detector: MAX_SAMPLES must be in 2..127");
  end
  if (RELEASE_THRESH > TRIG_THRESH) begin : g_bad_thresh
    $error("shot_detector: RELEASE_THRESH must not exceed TRIG_THRESH");
  end
  state_t state, state_d;
  logic [FLICK_W-1:0] peak, peak_d, p;
  logic [DUR_W-1:0] dur, dur_d, dur_inc;
  logic [POWER_BITS-1:0] pw;
  logic rep, cd_done;
  assign dur_inc = dur + 1'b1;
  always_comb begin
    state_d = state;
    peak_d = peak;
    dur_d = dur;
    case (state)
      S_IDLE: state_d = arm ? S_ARMED : S_IDLE;
      S_ARMED:
        if (!arm) state_d = S_IDLE;
        else if (sample_valid && flick >= TRIG_THRESH) begin
          state_d = S_TRACK;
          peak_d = flick;
          dur_d = DUR_W'(1);
        end
      S_TRACK:
        // arm takes priority over a sample arriving in the same cycle
        if (!arm) state_d = S_IDLE;
        else if (sample_valid) begin
          if (flick < RELEASE_THRESH) state_d = dur >= DUR_W'(MIN_SAMPLES) ? S_REPORT : S_ARMED;
          else begin
            peak_d = flick > peak ? flick : peak;
            dur_d = dur_inc;
            if (dur_inc == DUR_W'(MAX_SAMPLES)) state_d = S_REPORT;
          end
        end
      S_REPORT: state_d = S_COOLDOWN;
      S_COOLDOWN: if (cd_done) state_d = arm ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      peak <= '0;
      dur <= '0;
    end else begin
      state <= state_d;
      peak <= peak_d;
      dur <= dur_d;
    end
  end
  shot_cooldown_timer #(.CYCLES(COOLDOWN_CYCLES)) u_cooldown (
    .clk(clk),
    .rst(rst),
    .start(rep),
    .done(cd_done)
  );
  assign rep = state == S_REPORT;
  assign p = peak >> POWER_SHIFT;
  assign pw = p > FLICK_W'((1 << POWER_BITS) - 1) ? '1 : p[POWER_BITS-1:0];
`ifdef SHOT_DETECTOR_HOLD_EN
  logic [FLICK_W-1:0] hold_peak;
  logic [POWER_BITS-1:0] hold_pw;
  logic [DUR_W-1:0] hold_dur;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_peak <= '0;
      hold_pw <= '0;
      hold_dur <= '0;
    end else if (rep) begin
      hold_peak <= peak;
      hold_pw <= pw;
      hold_dur <= dur;
    end
  end
  assign shot_peak = rep ? peak : hold_peak;
  assign shot_power = rep ? pw : hold_pw;
  assign shot_dur = rep ? dur : hold_dur;
`else
  assign shot_peak = rep ? peak : '0;
  assign shot_power = rep ? pw : '0;
  assign shot_dur = rep ? dur : '0;
`endif
  assign shot_valid = rep;
  assign busy = state == S_TRACK || rep || state == S_COOLDOWN;
  assign state_dbg = state;
endmodule

// File: tb/tb_shot_detector.sv
// tb_shot_detector: directed stimulus with a scoreboard queue of expected shot reports
module tb_shot_detector;
  localparam int CD = 20;
`ifdef SHOT_DETECTOR_HOLD_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif
  typedef struct packed {
    logic [15:0] peak;
    logic [3:0] pw;
    logic [6:0] dur;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic [15:0] flick = '0;
  logic arm = 1'b0;
  logic shot_valid, busy;
  logic [15:0] shot_peak;
  logic [3:0] shot_power;
  logic [6:0] shot_dur;
  logic [2:0] state_dbg;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  shot_detector #(.COOLDOWN_CYCLES(CD)) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .flick(flick),
    .arm(arm),
    .shot_valid(shot_valid),
    .shot_peak(shot_peak),
    .shot_power(shot_power),
    .shot_dur(shot_dur),
    .busy(busy),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask
  task automatic step(input logic v, input int f);
    sample_valid = v;
    flick = f[15:0];
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask
  task automatic expect_shot(input int pk, input int pw, input int d);
    q.push_back({pk[15:0], pw[3:0], d[6:0]});
  endtask
  task automatic wait_ready();
    int n = 0;
    while (busy && n < 200) begin
      step(1'b0, 0);
      n++;
    end
    chk("cooldown_exit_timeout", int'(n < 200), 1);
    chk("state_after_cooldown", state_dbg, 1);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (shot_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shot actual peak %0d dur %0d required none", shot_peak, shot_dur);
      end else begin
        e = q.pop_front();
        chk("shot_peak", shot_peak, e.peak);
        chk("shot_power", shot_power, e.pw);
        chk("shot_dur", shot_dur, e.dur);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end
  initial begin
    int n;
    step(1'b0, 0);
    step(1'b0, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_valid", shot_valid, 0);
    chk("rst_peak", shot_peak, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    arm = 1'b1;
    step(1'b0, 0);
    chk("idle_to_armed", state_dbg, 1);
    expect_shot(400, 1, 3);
    step(1'b1, 50);
    chk("below_trig_stays_armed", state_dbg, 1);
    step(1'b1, 250);
    step(1'b1, 400);
    step(1'b1, 300);
    step(1'b1, 80);
    chk("report_state", state_dbg, 3);
    step(1'b0, 0);
    n = 1;
    chk("peak_after_pulse", shot_peak, HOLD ? 400 : 0);
    while (busy && n < 1000) begin
      n++;
      step(1'b0, 0);
    end
    chk("busy_cycles", n, 1 + CD);
    chk("armed_after_cooldown", state_dbg, 1);
    repeat (1000) step(1'b0, 0);
    chk("peak_1000_after", shot_peak, HOLD ? 400 : 0);
    step(1'b1, 250);
    step(1'b1, 260);
    step(1'b1, 40);
    chk("short_shot_dropped", state_dbg, 1);
    expect_shot(300, 1, 3);
    step(1'b1, 300);
    step(1'b1, 300);
    step(1'b1, 300);
    step(1'b1, 10);
    wait_ready();
    expect_shot(5000, 15, 64);
    repeat (70) step(1'b1, 5000);
    wait_ready();
    expect_shot(200, 0, 3);
    step(1'b1, 200);
    step(1'b1, 100);
    step(1'b1, 100);
    step(1'b1, 99);
    wait_ready();
    step(1'b1, 300);
    step(1'b1, 300);
    arm = 1'b0;
    step(1'b1, 50);
    chk("arm_abort_idle", state_dbg, 0);
    arm = 1'b1;
    step(1'b0, 0);
    expect_shot(300, 1, 3);
    step(1'b1, 300);
    step(1'b1, 300);
    step(1'b1, 300);
    step(1'b1, 10);
    step(1'b0, 0);
    chk("in_cooldown", state_dbg, 4);
    rst = 1'b1;
    step(1'b0, 0);
    rst = 1'b0;
    chk("rst_cd_state", state_dbg, 0);
    chk("rst_cd_busy", busy, 0);
    chk("rst_cd_peak", shot_peak, 0);
    chk("rst_cd_power", shot_power, 0);
    chk("rst_cd_dur", shot_dur, 0);
    step(1'b0, 0);
    expect_shot(250, 0, 3);
    step(1'b1, 250);
    step(1'b1, 250);
    step(1'b1, 250);
    step(1'b1, 10);
    step(1'b1, 1000);
    step(1'b1, 1000);
    step(1'b1, 1000);
    step(1'b1, 0);
    chk("cooldown_ignores_samples", state_dbg, 4);
    wait_ready();
    expect_shot(700, 2, 3);
    step(1'b1, 600);
    step(1'b1, 700);
    step(1'b1, 650);
    step(1'b1, 20);
    wait_ready();
    repeat (5) step(1'b0, 0);
    chk("pending_reports", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
